// File: rtl/led_chase_sequencer.sv
// led_chase_sequencer
//   Command-driven LED chase controller. A load command supplies a start
//   pattern, a motion mode and a step count. The system clock is divided
//   into step ticks of TICK_DIV cycles, and the pattern advances once per
//   tick until the step count runs out, an abort arrives, or (for a step
//   count of 0) indefinitely. Pause freezes the tick divider without losing
//   its position.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset, clears all state
//   cmd_valid    load command present
//   cmd_ready    command can be accepted (IDLE or DONE)
//   cmd_mode     0 shift-left refill, 1 rotate-left, 2 rotate-right, 3 bounce
//   cmd_pattern  initial LED pattern (0 is replaced by 1)
//   cmd_steps    number of steps, 0 = run until abort
//   pause        level, freezes stepping while high
//   abort        single-cycle request to stop and clear
//   led          registered LED drive
//   busy         high in RUN or PAUSE
//   done         one-cycle pulse after a bounded sequence completes

module led_chase_sequencer #(
  parameter int TICK_DIV = 100000000,
  parameter int WIDTH    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_pattern,
  input  logic [7:0]       cmd_steps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] led_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       steps_left, steps_n;
  logic [1:0]       mode, mode_n;
  logic             dir, dir_n;
  logic             done_n;
  logic             tick;
  logic [WIDTH:0]   step_res;

  // One pattern step. Returns {next_dir, next_led}. A step that would
  // leave the LEDs dark reloads the saved pattern instead, so the output
  // never shows an all-zero cycle while running.
  function automatic logic [WIDTH:0] step_fn(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] rld,
    input logic             d
  );
    logic [WIDTH-1:0] r;
    logic             nd;
    nd = d;
    r  = cur;
    case (m)
      2'd0: begin
        r = cur << 1;
        if (r == '0) r = rld;
      end
      2'd1: r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      2'd2: r = {cur[0], cur[WIDTH-1:1]};
      default: begin
        // Bounce: reverse when the leading edge sits at the end it is
        // moving towards, otherwise keep shifting in the current direction.
        if (d == DIR_LEFT && cur[WIDTH-1]) begin
          nd = DIR_RIGHT;
          r  = cur >> 1;
        end else if (d == DIR_RIGHT && cur[0]) begin
          nd = DIR_LEFT;
          r  = cur << 1;
        end else if (d == DIR_LEFT) begin
          r = cur << 1;
        end else begin
          r = cur >> 1;
        end
        if (r == '0) begin
          r  = rld;
          nd = DIR_LEFT;
        end
      end
    endcase
    return {nd, r};
  endfunction

  assign tick      = (cnt == CNT_MAX);
  assign step_res  = step_fn(mode, led, reload, dir);
  assign cmd_ready = (state == IDLE) || (state == DONE);
  assign busy      = (state == RUN) || (state == PAUSE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      led        <= '0;
      reload     <= '0;
      cnt        <= '0;
      steps_left <= '0;
      mode       <= '0;
      dir        <= DIR_LEFT;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      led        <= led_n;
      reload     <= reload_n;
      cnt        <= cnt_n;
      steps_left <= steps_n;
      mode       <= mode_n;
      dir        <= dir_n;
      done       <= done_n;
    end
  end

  // steps_left is only zero while running when the sequence is unbounded,
  // so it doubles as the bounded/unbounded flag.
  always_comb begin
    state_n  = state;
    led_n    = led;
    reload_n = reload;
    cnt_n    = cnt;
    steps_n  = steps_left;
    mode_n   = mode;
    dir_n    = dir;
    done_n   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      led_n   = '0;
      cnt_n   = '0;
      steps_n = '0;
      dir_n   = DIR_LEFT;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (cmd_valid) begin
            led_n    = (cmd_pattern == '0) ? WIDTH'(1) : cmd_pattern;
            reload_n = (cmd_pattern == '0) ? WIDTH'(1) : cmd_pattern;
            mode_n   = cmd_mode;
            steps_n  = cmd_steps;
            dir_n    = DIR_LEFT;
            cnt_n    = '0;
            state_n  = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            // Counter holds; a tick due this cycle waits for resume.
            state_n = PAUSE;
          end else if (tick) begin
            cnt_n = '0;
            led_n = step_res[WIDTH-1:0];
            dir_n = step_res[WIDTH];
            if (steps_left != 8'd0) begin
              steps_n = steps_left - 8'd1;
              if (steps_left == 8'd1) begin
                state_n = DONE;
                done_n  = 1'b1;
              end
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        PAUSE: begin
          if (!pause) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_chase_sequencer.sv
module tb_led_chase_sequencer;

  localparam int TICK_DIV = 4;
  localparam int WIDTH    = 8;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [WIDTH-1:0] cmd_pattern;
  logic [7:0]       cmd_steps;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] led;
  logic             busy;
  logic             done;

  int tests;
  int fails;

  led_chase_sequencer #(.TICK_DIV(TICK_DIV), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_pattern(cmd_pattern),
    .cmd_steps  (cmd_steps),
    .pause      (pause),
    .abort      (abort),
    .led        (led),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] p, input logic [7:0] s);
    cmd_mode    = m;
    cmd_pattern = p;
    cmd_steps   = s;
    cmd_valid   = 1'b1;
    cyc(1);
    cmd_valid   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_led;
    logic [7:0] cur_led;
    logic [7:0] seq_m1 [3];
    logic [7:0] seq_m3 [4];
    tests = 0;
    fails = 0;
    seq_m1 = '{8'h03, 8'h06, 8'h0C};
    seq_m3 = '{8'h80, 8'h40, 8'h20, 8'h10};

    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_pattern = 8'h00;
    cmd_steps = 8'd0; pause = 1'b0; abort = 1'b0;
    #1;
    chk("rst_led", led, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Mode 0 shift-left refill, unbounded: 01,02,...,80,01 with no dark cycle.
    send(2'd0, 8'h01, 8'd0);
    chk("m0_load", led, 8'h01);
    chk("m0_busy", busy, 1'b1);
    chk("m0_ready", cmd_ready, 1'b0);
    cur_led = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      exp_led = (k == 8) ? 8'h01 : (8'h01 << k);
      for (int c = 0; c < 4; c++) begin
        cyc(1);
        chk($sformatf("m0_step%0d_c%0d", k, c), led, (c == 3) ? exp_led : cur_led);
      end
      cur_led = exp_led;
    end
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("m0_abort_led", led, 8'h00);
    chk("m0_abort_busy", busy, 1'b0);

    // Mode 1 rotate-left, 3 steps.
    send(2'd1, 8'h81, 8'd3);
    chk("m1_load", led, 8'h81);
    for (int s = 0; s < 3; s++) begin
      cyc(3);
      chk($sformatf("m1_hold%0d", s), led, (s == 0) ? 8'h81 : seq_m1[s-1]);
      cyc(1);
      chk($sformatf("m1_step%0d", s), led, seq_m1[s]);
      if (s < 2) chk($sformatf("m1_nodone%0d", s), done, 1'b0);
    end
    chk("m1_done", done, 1'b1);
    chk("m1_busy", busy, 1'b0);
    chk("m1_ready", cmd_ready, 1'b1);
    cyc(1);
    chk("m1_done_pulse", done, 1'b0);
    chk("m1_hold_led", led, 8'h0C);

    // Mode 3 bounce from DONE, 4 steps: reverses at the MSB.
    send(2'd3, 8'h40, 8'd4);
    chk("m3_load", led, 8'h40);
    for (int s = 0; s < 4; s++) begin
      cyc(4);
      chk($sformatf("m3_step%0d", s), led, seq_m3[s]);
    end
    chk("m3_done", done, 1'b1);
    cyc(1);
    chk("m3_done_pulse", done, 1'b0);
    chk("m3_hold_led", led, 8'h10);

    // Mode 2 rotate-right with a 10-cycle pause mid-interval.
    send(2'd2, 8'h01, 8'd0);
    cyc(1);
    pause = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      chk($sformatf("m2_paused%0d", c), led, 8'h01);
    end
    chk("m2_pause_busy", busy, 1'b1);
    pause = 1'b0;
    cyc(3);
    chk("m2_pre_tick", led, 8'h01);
    cyc(1);
    chk("m2_tick", led, 8'h80);
    // Pause rising on the tick cycle suppresses the step.
    cyc(3);
    chk("m2_before_tick", led, 8'h80);
    pause = 1'b1;
    cyc(1);
    chk("m2_tick_suppressed", led, 8'h80);
    cyc(1);
    chk("m2_tick_suppressed2", led, 8'h80);
    pause = 1'b0;
    cyc(1);
    chk("m2_resume_edge", led, 8'h80);
    cyc(1);
    chk("m2_resume_step", led, 8'h40);

    // Abort while paused.
    pause = 1'b1;
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    pause = 1'b0;
    chk("abort_led", led, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cmd_ready, 1'b1);
    chk("abort_done", done, 1'b0);
    cyc(2);
    chk("abort_done_later", done, 1'b0);
    chk("abort_idle_led", led, 8'h00);

    // Zero pattern loads as 01; a command during RUN is ignored.
    send(2'd1, 8'h00, 8'd2);
    chk("zero_load", led, 8'h01);
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_pattern = 8'hAA; cmd_steps = 8'd0;
    chk("run_ready", cmd_ready, 1'b0);
    cyc(3);
    chk("run_ignore", led, 8'h01);
    cyc(1);
    chk("run_step", led, 8'h02);
    cmd_valid = 1'b0;
    cyc(4);
    chk("zero_final", led, 8'h04);
    chk("zero_done", done, 1'b1);

    // Asynchronous reset mid-interval.
    send(2'd0, 8'h0F, 8'd0);
    cyc(2);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_led", led, 8'h00);
    chk("areset_busy", busy, 1'b0);
    chk("areset_ready", cmd_ready, 1'b1);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("areset_done", done, 1'b0);
    send(2'd1, 8'h11, 8'd1);
    chk("post_reset_load", led, 8'h11);
    cyc(4);
    chk("post_reset_step", led, 8'h22);
    chk("post_reset_done", done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
